seg7_capture: RTL and testbench
===============================

// Module: seg7_capture
// PURPOSE
//  Receive side of the 7-segment bus driven by the key counter/display block.
//  Samples seg[6:0] while seg_en is high, waits for a stable pattern, decodes
//  it back to a BCD digit and hands it out on a valid/ready port.
//  Feeds the self-check monitor and readback logic that confirm the displayed count.
// PARAMETERS
//  STABLE_CYCLES  16  consecutive identical samples needed to accept a pattern (>=2)
// PORTS
//  clk          in   1  single clock; all logic on posedge
//  rst          in   1  synchronous, active-high reset
//  seg          in   7  segment pattern, bit6=a .. bit0=g, 1 = lit
//  seg_en       in   1  display enable; pattern is meaningful only when high
//  digit        out  4  decoded digit 0..9 (4'hF for blank when enabled)
//  digit_valid  out  1  digit holds an unconsumed capture
//  digit_ready  in   1  consumer accepts digit when valid & ready
//  wrap         out  1  one-cycle pulse: accepted digit 0 directly after accepted 9
//  bad_pat      out  1  sticky: stable pattern not in the decode table
//  overrun      out  1  sticky: new capture while previous still unconsumed
// BEHAVIOUR
//  Reset (rst=1 at posedge): digit=0, digit_valid=0, wrap=0, bad_pat=0,
//   overrun=0, stab_cnt=0, last_seg=0, prev_digit=0, state=IDLE.
//  Decode table (seg -> digit): 1111110->0, 0110000->1, 1101101->2,
//   1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7,
//   1111111->8, 1111011->9; every other pattern is illegal.
//  FSM:
//   IDLE : seg_en=0. On seg_en=1 -> TRACK, last_seg<=seg, stab_cnt<=1.
//   TRACK: seg==last_seg -> stab_cnt++; else last_seg<=seg, stab_cnt<=1.
//          stab_cnt reaches STABLE_CYCLES -> ACCEPT action, -> HOLD.
//   HOLD : stay while seg==last_seg (no re-capture of same pattern).
//          seg!=last_seg -> TRACK, last_seg<=seg, stab_cnt<=1.
//   Any state: seg_en=0 -> IDLE, stab_cnt<=0; digit/valid/flags untouched.
//  ACCEPT action (same edge stab_cnt hits STABLE_CYCLES):
//   legal  -> digit<=decode, digit_valid<=1, prev_digit<=decode;
//             wrap<=1 for one cycle if decode==0 and prev_digit==9.
//   illegal-> bad_pat<=1, digit/digit_valid unchanged.
//  Latency: pattern applied at cycle N, stable, seg_en high -> digit_valid high
//   at edge N+STABLE_CYCLES-1 after first sample; overall STABLE_CYCLES cycles.
//  Handshake: valid & ready clears digit_valid next edge. If a legal ACCEPT and
//   valid & ready occur on the same edge, new digit wins, digit_valid stays 1,
//   overrun NOT set. Legal ACCEPT with valid=1 and ready=0: overwrite digit,
//   set overrun.
//  stab_cnt saturates at STABLE_CYCLES; width $clog2(STABLE_CYCLES+1).
//  Sticky flags clear only on rst.
//  rst mid-capture: all state discarded, restart from IDLE next cycle.
// CONFIGURATION
//  SEG7_CAP_BLANK_EN defined: pattern 0000000 is legal and decodes to 4'hF;
//   it does not update prev_digit and never causes wrap.
//  Not defined: 0000000 is illegal (sets bad_pat like any unknown pattern).
// TESTING
//  seg_en=1, seg=1111001 held 16 cycles -> digit=3, digit_valid=1 on 16th
//   edge; ready=1 one cycle -> digit_valid=0; no re-capture while held.
//  seg=1011011 for 10 cycles then glitch 1011111 then 1011011 for 16 ->
//   one capture only, digit=5; the 10-cycle run produces no capture.
//  Accept 9 (1111011) then 0 (1111110), ready=1 -> wrap pulses exactly one
//   cycle with the 0 capture; bad_pat=0, overrun=0.
//  Stable 1000001 for 16 cycles -> bad_pat=1, digit_valid unchanged; 0000000
//   -> bad_pat=1 without SEG7_CAP_BLANK_EN, digit=F valid with it.
//  Two legal captures (2 then 7), ready=0 -> digit=7, digit_valid=1,
//   overrun=1; seg_en drop mid-TRACK or rst pulse -> no capture from partial run.

Source files
------------

// File: rtl/seg7_capture_if.sv
// Bus between the 7-segment driver side and the capture block: raw segment
// lines in, decoded digit out on a valid/ready port with status flags.
interface seg7_capture_if;
    logic [6:0] seg;
    logic       seg_en;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_ready;
    logic       wrap;
    logic       bad_pat;
    logic       overrun;

    modport master (
        output seg, seg_en, digit_ready,
        input  digit, digit_valid, wrap, bad_pat, overrun
    );

    modport slave (
        input  seg, seg_en, digit_ready,
        output digit, digit_valid, wrap, bad_pat, overrun
    );
endinterface

// File: rtl/seg7_capture.sv
// Samples a 7-segment pattern, waits for STABLE_CYCLES identical samples and
// decodes it to BCD. Define SEG7_CAP_BLANK_EN to accept the blank pattern as 4'hF.
module seg7_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input logic          clk,
    input logic          rst,
    seg7_capture_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_e;

    state_e        state_q;
    logic [CW-1:0] stab_cnt_q;
    logic [6:0]    last_seg_q;
    logic [3:0]    prev_digit_q;
    logic [3:0]    digit_q;
    logic          digit_valid_q;
    logic          wrap_q;
    logic          bad_pat_q;
    logic          overrun_q;

    logic          dec_legal;
    logic [3:0]    dec_val;
    logic          same;
    logic [CW-1:0] cnt_inc;
    logic          accept;

    always_comb begin
        dec_legal = 1'b1;
        dec_val   = 4'h0;
        case (bus.seg)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
`ifdef SEG7_CAP_BLANK_EN
            7'b0000000: dec_val = 4'hF;
`endif
            default:    dec_legal = 1'b0;
        endcase
    end

    // The accept fires on the edge where the counter would step onto STABLE_CYCLES.
    always_comb begin
        same    = (bus.seg == last_seg_q);
        cnt_inc = (stab_cnt_q == CNT_MAX) ? stab_cnt_q : stab_cnt_q + CNT_ONE;
        accept  = bus.seg_en && (state_q == TRACK) && same &&
                  (stab_cnt_q != CNT_MAX) && (cnt_inc == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            stab_cnt_q    <= '0;
            last_seg_q    <= '0;
            prev_digit_q  <= '0;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            wrap_q        <= 1'b0;
            bad_pat_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (digit_valid_q && bus.digit_ready)
                digit_valid_q <= 1'b0;

            if (!bus.seg_en) begin
                state_q    <= IDLE;
                stab_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q    <= TRACK;
                        last_seg_q <= bus.seg;
                        stab_cnt_q <= CNT_ONE;
                    end
                    TRACK: begin
                        if (same) begin
                            stab_cnt_q <= cnt_inc;
                            if (accept)
                                state_q <= HOLD;
                        end else begin
                            last_seg_q <= bus.seg;
                            stab_cnt_q <= CNT_ONE;
                        end
                    end
                    HOLD: begin
                        if (!same) begin
                            state_q    <= TRACK;
                            last_seg_q <= bus.seg;
                            stab_cnt_q <= CNT_ONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            // A legal capture overrides the handshake clear on the same edge.
            if (accept) begin
                if (dec_legal) begin
                    digit_q       <= dec_val;
                    digit_valid_q <= 1'b1;
                    if (digit_valid_q && !bus.digit_ready)
                        overrun_q <= 1'b1;
                    if (dec_val != 4'hF) begin
                        prev_digit_q <= dec_val;
                        wrap_q       <= (dec_val == 4'd0) && (prev_digit_q == 4'd9);
                    end
                end else begin
                    bad_pat_q <= 1'b1;
                end
            end
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.wrap        = wrap_q;
    assign bus.bad_pat     = bad_pat_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_seg7_capture.sv
// Random and directed stimulus for seg7_capture, checked every cycle against
// a run-length reference model of the capture rules.
module tb_seg7_capture;
    localparam int S = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_capture_if bus ();

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] pat_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011};

    // reference state
    logic [3:0] m_digit, m_prev;
    logic       m_valid, m_wrap, m_bad, m_ovr;
    int         run_len;
    logic [6:0] run_pat;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] lookup(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (pat_tab[i] == p) return {1'b1, 4'(i)};
`ifdef SEG7_CAP_BLANK_EN
        if (p == 7'b0000000) return {1'b1, 4'hF};
`endif
        return 5'h0;
    endfunction

    task automatic model_step();
        logic       old_v;
        logic [4:0] d;
        int         nl;
        logic       acc;
        if (rst) begin
            m_digit = 0; m_prev = 0; m_valid = 0; m_wrap = 0; m_bad = 0; m_ovr = 0;
            run_len = 0; run_pat = 0;
        end else begin
            m_wrap = 0;
            old_v  = m_valid;
            if (m_valid && bus.digit_ready) m_valid = 0;
            acc = 0;
            if (!bus.seg_en) begin
                run_len = 0;
            end else begin
                if (run_len > 0 && bus.seg == run_pat) begin
                    nl  = (run_len >= S) ? S : run_len + 1;
                    acc = (run_len < S) && (nl == S);
                end else begin
                    run_pat = bus.seg;
                    nl = 1;
                end
                run_len = nl;
            end
            if (acc) begin
                d = lookup(bus.seg);
                if (d[4]) begin
                    if (old_v && !bus.digit_ready) m_ovr = 1;
                    m_digit = d[3:0];
                    m_valid = 1;
                    if (d[3:0] != 4'hF) begin
                        m_wrap = (d[3:0] == 0) && (m_prev == 9);
                        m_prev = d[3:0];
                    end
                end else begin
                    m_bad = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("digit",   16'(bus.digit),       16'(m_digit));
        chk("valid",   16'(bus.digit_valid), 16'(m_valid));
        chk("wrap",    16'(bus.wrap),        16'(m_wrap));
        chk("bad_pat", 16'(bus.bad_pat),     16'(m_bad));
        chk("overrun", 16'(bus.overrun),     16'(m_ovr));
    endtask

    task automatic run(input logic [6:0] s, input logic en, input logic rdy, input int n);
        bus.seg = s; bus.seg_en = en; bus.digit_ready = rdy;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1;
        run(7'h0, 0, 0, 2);
        rst = 0;
    endtask

    int wrap_cnt;

    initial begin
        bus.seg = 0; bus.seg_en = 0; bus.digit_ready = 0;
        do_reset();

        // hold 3 for S cycles, consume, then no re-capture while held
        run(7'b1111001, 1, 0, S);
        chk("t1_digit", 16'(bus.digit), 16'd3);
        chk("t1_valid", 16'(bus.digit_valid), 16'd1);
        run(7'b1111001, 1, 1, 1);
        chk("t1_consumed", 16'(bus.digit_valid), 16'd0);
        run(7'b1111001, 1, 0, 6);
        chk("t1_no_recap", 16'(bus.digit_valid), 16'd0);

        // short run + glitch gives one capture only
        run(7'b1011011, 1, 0, 10);
        run(7'b1011111, 1, 0, 1);
        run(7'b1011011, 1, 0, S - 1);
        chk("t2_early", 16'(bus.digit_valid), 16'd0);
        run(7'b1011011, 1, 0, 1);
        chk("t2_digit", 16'(bus.digit), 16'd5);
        run(7'b1011011, 1, 1, 1);

        // 9 then 0 with ready high -> single wrap pulse
        run(7'b1111011, 1, 1, S + 2);
        bus.seg = 7'b1111110;
        wrap_cnt = 0;
        repeat (S + 3) begin
            tick();
            if (bus.wrap) wrap_cnt++;
        end
        chk("t3_wrap_cnt", 16'(wrap_cnt), 16'd1);
        chk("t3_flags", {14'b0, bus.bad_pat, bus.overrun}, 16'd0);

        // illegal and blank patterns
        run(7'b1000001, 1, 0, S);
        chk("t4_bad", 16'(bus.bad_pat), 16'd1);
        chk("t4_valid", 16'(bus.digit_valid), 16'd0);
        do_reset();
        run(7'b0000000, 1, 0, S + 1);
`ifdef SEG7_CAP_BLANK_EN
        chk("t4_blank", {11'b0, bus.bad_pat, bus.digit}, 16'h000F);
`else
        chk("t4_blank", {11'b0, bus.bad_pat, bus.digit_valid, 3'b0}, 16'h0010);
`endif

        // overrun: 2 then 7 without ready
        do_reset();
        run(7'b1101101, 1, 0, S + 1);
        run(7'b1110000, 1, 0, S + 1);
        chk("t5_digit", 16'(bus.digit), 16'd7);
        chk("t5_ovr", 16'(bus.overrun), 16'd1);

        // partial runs interrupted by seg_en drop or reset
        run(7'b0110000, 1, 1, 2);
        run(7'b0110000, 1, 0, S - 4);
        run(7'b0110000, 0, 0, 3);
        run(7'b0110000, 1, 0, S - 2);
        chk("t6_en_drop", 16'(bus.digit), 16'd7);
        rst = 1; run(7'b0110000, 1, 0, 1); rst = 0;
        run(7'b0110000, 1, 0, S - 1);
        chk("t6_rst", 16'(bus.digit_valid), 16'd0);

        // random segments
        for (int k = 0; k < 300; k++) begin
            int r, len;
            logic [6:0] p;
            logic en;
            r = $urandom_range(0, 99);
            if (r < 60)      p = pat_tab[$urandom_range(0, 9)];
            else if (r < 75) p = 7'b0000000;
            else             p = 7'($urandom);
            en  = ($urandom_range(0, 9) != 0);
            len = $urandom_range(1, 22);
            rst = ($urandom_range(0, 49) == 0);
            bus.seg = p; bus.seg_en = en;
            for (int c = 0; c < len; c++) begin
                bus.digit_ready = ($urandom_range(0, 3) == 0);
                tick();
                rst = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
